// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute control for the 32-bit core.
// Owns PC and IR, shares the RAM port between fetch and LDR/STR, drives datapath strobes.
module cpu_sequencer #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_ready,
  input  logic [31:0]       instr_in,
  input  logic [3:0]        flags,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       ir,
  output logic              mem_req,
  output logic              sel_add_bus,
  output logic              ram_rw,
  output logic              sel_ldr_bus,
  output logic              reg_we,
  output logic              flags_we,
  output logic              halted,
  output logic [15:0]       retired,
  output logic [2:0]        state
);

  localparam logic [3:0] OP_B    = 4'hA;
  localparam logic [3:0] OP_LDR  = 4'hC;
  localparam logic [3:0] OP_STR  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t             st_q;
  state_t             st_d;
  logic [ADDR_W-1:0]  pc_d;
  logic [31:0]        ir_d;
  logic [15:0]        retired_d;
  logic [3:0]         cond;
  logic [3:0]         op;
  logic [3:0]         op_d;
  logic [15:0]        imm;
  logic               fn, fz, fc, fv;
  logic               cond_ok;

  assign cond  = ir[31:28];
  assign op    = ir[27:24];
  assign imm   = ir[18:3];
  assign op_d  = ir_d[27:24];
  assign {fn, fz, fc, fv} = flags;
  assign state = st_q;

  function automatic logic is_alu(input logic [3:0] o);
    return (o != OP_B) && (o != OP_LDR) && (o != OP_STR) && (o != OP_HALT);
  endfunction

  // Condition check against the live NZCV; only consumed in DECODE
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'h0:    cond_ok = 1'b1;
      4'h1:    cond_ok = fz;
      4'h2:    cond_ok = !fz;
      4'h3:    cond_ok = fc;
      4'h4:    cond_ok = !fc;
      4'h5:    cond_ok = fn;
      4'h6:    cond_ok = !fn;
      4'h7:    cond_ok = fv;
      4'h8:    cond_ok = !fv;
      4'h9:    cond_ok = fc && !fz;
      4'hA:    cond_ok = !fc || fz;
      4'hB:    cond_ok = (fn == fv);
      4'hC:    cond_ok = (fn != fv);
      4'hD:    cond_ok = !fz && (fn == fv);
      4'hE:    cond_ok = fz || (fn != fv);
      default: cond_ok = 1'b0;
    endcase
  end

  // Next-state, PC, IR and retire counter
  always_comb begin
    st_d      = st_q;
    pc_d      = pc;
    ir_d      = ir;
    retired_d = retired;
    case (st_q)
      S_IDLE: if (start) st_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          ir_d = instr_in;
          pc_d = pc + ADDR_W'(1);
          st_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!cond_ok) begin
          retired_d = retired + 16'd1;
          st_d      = S_FETCH;
        end else if (op == OP_HALT) begin
          st_d = S_HALT;
        end else begin
          st_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op == OP_B) begin
          pc_d      = ADDR_W'(imm);
          retired_d = retired + 16'd1;
          st_d      = S_FETCH;
        end else if ((op == OP_LDR) || (op == OP_STR)) begin
          st_d = S_MEM;
        end else begin
          st_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op == OP_STR) begin
            retired_d = retired + 16'd1;
            st_d      = S_FETCH;
          end else begin
            st_d = S_WB;
          end
        end
      end
      S_WB: begin
        retired_d = retired + 16'd1;
        st_d      = S_FETCH;
      end
      S_HALT:  st_d = S_HALT;
      default: st_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the upcoming state so they align with it and never see inputs combinationally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q        <= S_IDLE;
      pc          <= RESET_PC;
      ir          <= '0;
      retired     <= '0;
      mem_req     <= 1'b0;
      sel_add_bus <= 1'b0;
      ram_rw      <= 1'b0;
      sel_ldr_bus <= 1'b0;
      reg_we      <= 1'b0;
      flags_we    <= 1'b0;
      halted      <= 1'b0;
    end else begin
      st_q        <= st_d;
      pc          <= pc_d;
      ir          <= ir_d;
      retired     <= retired_d;
      mem_req     <= (st_d == S_FETCH) || (st_d == S_MEM);
      sel_add_bus <= (st_d == S_MEM);
      ram_rw      <= (st_d == S_MEM) && (op_d == OP_STR);
      sel_ldr_bus <= (st_d == S_WB) && (op_d == OP_LDR);
      reg_we      <= (st_d == S_WB);
      flags_we    <= (st_d == S_WB) && ir_d[23] && is_alu(op_d);
      halted      <= (st_d == S_HALT);
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: instruction-level reference model checked against the sequencer,
// with randomized instructions, flags and RAM wait states.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_ready;
  logic [31:0] instr_in;
  logic [3:0]  flags;
  logic [15:0] pc;
  logic [31:0] ir;
  logic        mem_req, sel_add_bus, ram_rw, sel_ldr_bus, reg_we, flags_we, halted;
  logic [15:0] retired;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  logic [15:0] m_pc;
  logic [15:0] m_ret;

  typedef struct packed {
    logic [7:0]  cycles;
    logic [3:0]  reg_we;
    logic [3:0]  flags_we;
    logic [3:0]  ldr;
    logic [3:0]  dmem;
    logic [3:0]  wr;
    logic [15:0] pc;
    logic [15:0] ret;
    logic        halted;
    logic        pc_stable;
  } obs_t;

  cpu_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_ready(mem_ready),
    .instr_in(instr_in), .flags(flags), .pc(pc), .ir(ir),
    .mem_req(mem_req), .sel_add_bus(sel_add_bus), .ram_rw(ram_rw),
    .sel_ldr_bus(sel_ldr_bus), .reg_we(reg_we), .flags_we(flags_we),
    .halted(halted), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, ge;
    {n, z, cy, v} = f;
    ge = (n == v);
    case (c)
      4'd0:  return 1'b1;
      4'd1:  return z;
      4'd2:  return !z;
      4'd3:  return cy;
      4'd4:  return !cy;
      4'd5:  return n;
      4'd6:  return !n;
      4'd7:  return v;
      4'd8:  return !v;
      4'd9:  return cy && !z;
      4'd10: return !cy || z;
      4'd11: return ge;
      4'd12: return !ge;
      4'd13: return !z && ge;
      4'd14: return z || !ge;
      default: return 1'b0;
    endcase
  endfunction

  // Whole-instruction outcome: cycles FETCH-entry to next FETCH (or HALT), strobe counts, architectural state
  function automatic obs_t model(input logic [31:0] instr, input logic [3:0] fl, input int fw, input int mw);
    obs_t e;
    logic [3:0] op;
    op = instr[27:24];
    e = '0;
    e.pc_stable = 1'b1;
    e.pc = m_pc + 16'd1;
    e.ret = m_ret + 16'd1;
    e.cycles = 8'(fw);
    if (!cond_pass(instr[31:28], fl)) begin
      e.cycles = e.cycles + 8'd2;
    end else if (op == 4'hF) begin
      e.cycles = e.cycles + 8'd2;
      e.ret = m_ret;
      e.halted = 1'b1;
    end else if (op == 4'hA) begin
      e.cycles = e.cycles + 8'd3;
      e.pc = instr[18:3];
    end else if (op == 4'hC) begin
      e.cycles = e.cycles + 8'(5 + mw);
      e.reg_we = 4'd1;
      e.ldr = 4'd1;
      e.dmem = 4'(1 + mw);
    end else if (op == 4'hD) begin
      e.cycles = e.cycles + 8'(4 + mw);
      e.dmem = 4'(1 + mw);
      e.wr = 4'(1 + mw);
    end else begin
      e.cycles = e.cycles + 8'd4;
      e.reg_we = 4'd1;
      e.flags_we = {3'b000, instr[23]};
    end
    return e;
  endfunction

  // Runs one instruction from a FETCH negedge, acting as RAM responder and recording what the DUT did
  task automatic exec_one(input logic [31:0] instr, input logic [3:0] fl, input int fw, input int mw, output obs_t o);
    int fcnt;
    int mcnt;
    bit moved;
    logic [15:0] pc0;
    fcnt = fw;
    mcnt = mw;
    moved = 1'b0;
    pc0 = pc;
    o = '0;
    o.pc_stable = 1'b1;
    instr_in = instr;
    flags = fl;
    while (o.cycles < 8'd40) begin
      if (reg_we) o.reg_we = o.reg_we + 4'd1;
      if (flags_we) o.flags_we = o.flags_we + 4'd1;
      if (reg_we && sel_ldr_bus) o.ldr = o.ldr + 4'd1;
      if (state == 3'd1 && pc != pc0) o.pc_stable = 1'b0;
      if (mem_req && !sel_add_bus) begin
        mem_ready = (fcnt == 0);
        if (fcnt > 0) fcnt--;
      end else if (mem_req) begin
        o.dmem = o.dmem + 4'd1;
        if (ram_rw) o.wr = o.wr + 4'd1;
        mem_ready = (mcnt == 0);
        if (mcnt > 0) mcnt--;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      o.cycles = o.cycles + 8'd1;
      @(negedge clk);
      if (state != 3'd1) moved = 1'b1;
      if (moved && (state == 3'd1 || state == 3'd6)) break;
    end
    o.pc = pc;
    o.ret = retired;
    o.halted = halted;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({state, mem_req, sel_add_bus} !== {3'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL start_fetch got state=%0d req=%b sel=%b exp state=1 req=1 sel=0", state, mem_req, sel_add_bus);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; mem_ready = 1'b0; instr_in = '0; flags = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({state, pc, ir, retired} !== {3'd0, 16'd0, 32'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_regs got state=%0d pc=%h ir=%h ret=%0d exp all 0", state, pc, ir, retired);
    end
    checks++;
    if ({mem_req, sel_add_bus, ram_rw, sel_ldr_bus, reg_we, flags_we, halted} !== 7'd0) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 0000000", {mem_req, sel_add_bus, ram_rw, sel_ldr_bus, reg_we, flags_we, halted});
    end
    rst = 1'b1;
    repeat (5) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    checks++;
    if ({state, pc, mem_req, reg_we} !== {3'd0, 16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL idle_no_start got state=%0d pc=%h req=%b we=%b exp idle", state, pc, mem_req, reg_we);
    end
    start_pulse();
    m_pc = 16'd0;
    m_ret = 16'd0;
  endtask

  task automatic test_alu();
    obs_t o, e;
    logic [31:0] in;
    in = {8'h01, 1'b1, 23'($urandom)};
    e = model(in, 4'($urandom), 0, 0);
    exec_one(in, 4'($urandom), 0, 0, o);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL alu got %p exp %p", o, e);
    end
    checks++;
    if (o.pc !== 16'd1 || o.ret !== 16'd1) begin
      errors++;
      $display("FAIL alu_first got pc=%h ret=%0d exp pc=0001 ret=1", o.pc, o.ret);
    end
    m_pc = e.pc; m_ret = e.ret;
  endtask

  task automatic test_ldr_wait();
    obs_t o, e;
    logic [31:0] in;
    in = {8'h0C, 24'($urandom)};
    e = model(in, 4'h0, 0, 3);
    exec_one(in, 4'h0, 0, 3, o);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL ldr_wait got %p exp %p", o, e);
    end
    checks++;
    if (o.cycles !== 8'd8 || o.dmem !== 4'd4) begin
      errors++;
      $display("FAIL ldr_latency got cycles=%0d dmem=%0d exp cycles=8 dmem=4", o.cycles, o.dmem);
    end
    m_pc = e.pc; m_ret = e.ret;
  endtask

  task automatic test_cond();
    obs_t o, e;
    logic [31:0] in;
    in = {8'h11, 1'b1, 23'($urandom)};
    e = model(in, 4'b0100, 1, 0);
    exec_one(in, 4'b0100, 1, 0, o);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL cond_eq got %p exp %p", o, e);
    end
    m_pc = e.pc; m_ret = e.ret;
    in = {8'h21, 1'b1, 23'($urandom)};
    e = model(in, 4'b0100, 0, 0);
    exec_one(in, 4'b0100, 0, 0, o);
    checks++;
    if (o.reg_we !== 4'd0 || o.flags_we !== 4'd0 || o.cycles !== 8'd2 || o.ret !== m_ret + 16'd1) begin
      errors++;
      $display("FAIL cond_ne got we=%0d fwe=%0d cycles=%0d ret=%0d exp 0 0 2 %0d", o.reg_we, o.flags_we, o.cycles, o.ret, m_ret + 16'd1);
    end
    m_pc = e.pc; m_ret = e.ret;
  endtask

  task automatic test_branch_wrap();
    obs_t o, e;
    logic [31:0] in;
    in = {8'h0A, 5'b0, 16'hFFFF, 3'b0};
    e = model(in, 4'h0, 0, 0);
    exec_one(in, 4'h0, 0, 0, o);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL branch got %p exp %p", o, e);
    end
    m_pc = e.pc; m_ret = e.ret;
    in = {8'h03, 24'($urandom)};
    e = model(in, 4'h0, 2, 0);
    exec_one(in, 4'h0, 2, 0, o);
    checks++;
    if (o.pc !== 16'h0000 || o !== e) begin
      errors++;
      $display("FAIL pc_wrap got %p exp %p", o, e);
    end
    m_pc = e.pc; m_ret = e.ret;
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [31:0] in;
    logic [3:0] fl;
    int fw, mw;
    for (int i = 0; i < 60; i++) begin
      in = $urandom;
      in[27:24] = 4'($urandom_range(0, 14));
      fl = 4'($urandom);
      fw = int'($urandom_range(0, 3));
      mw = int'($urandom_range(0, 3));
      e = model(in, fl, fw, mw);
      exec_one(in, fl, fw, mw, o);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random[%0d] instr=%h flags=%b got %p exp %p", i, in, fl, o, e);
      end
      m_pc = e.pc; m_ret = e.ret;
    end
  endtask

  task automatic test_reset_mid_str();
    int n;
    n = 0;
    instr_in = {8'h0D, 24'($urandom)};
    flags = 4'h0;
    while (state != 3'd4 && n < 10) begin
      mem_ready = (state == 3'd1);
      @(negedge clk);
      n++;
    end
    mem_ready = 1'b0;
    checks++;
    if ({state, mem_req, sel_add_bus, ram_rw} !== {3'd4, 3'b111}) begin
      errors++;
      $display("FAIL str_mem got state=%0d req=%b sel=%b rw=%b exp 4 1 1 1", state, mem_req, sel_add_bus, ram_rw);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({state, mem_req, ram_rw, sel_add_bus, reg_we, flags_we} !== 8'd0 || pc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_abort got state=%0d req=%b rw=%b pc=%h exp 0 0 0 0000", state, mem_req, ram_rw, pc);
    end
    repeat (3) begin
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({mem_req, ram_rw, reg_we, flags_we} !== 4'd0) begin
        errors++;
        $display("FAIL reset_held got %b exp 0000", {mem_req, ram_rw, reg_we, flags_we});
      end
    end
    rst = 1'b1;
    @(negedge clk);
    start_pulse();
    m_pc = 16'd0;
    m_ret = 16'd0;
  endtask

  task automatic test_halt();
    obs_t o, e;
    logic [31:0] in;
    in = {8'h0F, 24'($urandom)};
    e = model(in, 4'h0, 1, 0);
    exec_one(in, 4'h0, 1, 0, o);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL halt got %p exp %p", o, e);
    end
    repeat (20) begin
      start = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({halted, state, mem_req, reg_we, flags_we} !== {1'b1, 3'd6, 3'b000} || pc !== e.pc) begin
        errors++;
        $display("FAIL halt_hold got halted=%b state=%0d req=%b pc=%h exp 1 6 0 %h", halted, state, mem_req, pc, e.pc);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_ldr_wait();
    test_cond();
    test_branch_wrap();
    test_random();
    test_reset_mid_str();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control FSM for the 32-bit processor datapath. Owns the program counter and instruction register, and shares the single RAM address port between instruction fetch and LDR/STR data access. Decodes the condition and opcode fields against the NZCV flags, then issues the write enables and mux selects to the register bank, flags register, address-bus mux and LDR-bus mux. It replaces the free-running program counter wrapper at the top of the core.

## Interface
Parameters:
- ADDR_W, 16, width of PC and RAM word address
- RESET_PC, 16'h0000, PC value after reset

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE and begin fetching at the current PC
- mem_ready  in  1  RAM handshake; a transfer completes on a cycle with mem_req=1 and mem_ready=1
- instr_in  in  32  RAM fetch data, sampled when a FETCH transfer completes
- flags  in  4  current NZCV from the flags register, in the order {N,Z,C,V}
- pc  out  ADDR_W  instruction address, driven to the address-bus mux PC input
- ir  out  32  instruction register, driven to the decode field splits
- mem_req  out  1  RAM access request
- sel_add_bus  out  1  0 selects the PC (fetch), 1 selects the data address
- ram_rw  out  1  1 means write (STR)
- sel_ldr_bus  out  1  1 selects RAM data into the register bank, 0 selects the ALU result
- reg_we  out  1  register bank write strobe
- flags_we  out  1  flags register write strobe
- halted  out  1  high in HALT
- retired  out  16  count of completed instructions
- state  out  3  encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6

## Operation
- Decode fields, taken from ir:
  - cond = ir[31:28]
  - op = ir[27:24]
  - s = ir[23]
  - imm = ir[18:3]
- Opcode classes:
  - 4'hC LDR
  - 4'hD STR
  - 4'hA B (pc <= imm)
  - 4'hF HALT
  - all others are ALU ops
- Condition codes:
  - 0 AL, 1 EQ(Z), 2 NE(!Z), 3 CS(C), 4 CC(!C), 5 MI(N), 6 PL(!N), 7 VS(V), 8 VC(!V)
  - 9 HI(C&!Z), A LS(!C|Z), B GE(N==V), C LT(N!=V), D GT(!Z&N==V), E LE(Z|N!=V), F NV(never)
  - cond is evaluated in DECODE against the flags value present in that cycle.
- State transitions:
  - IDLE: goes to FETCH when start=1.
  - FETCH: mem_req=1, sel_add_bus=0. Waits for mem_ready. On completion: ir <= instr_in, pc <= pc+1 (wraps at 2^ADDR_W-1 to 0), then DECODE.
  - DECODE: if cond fails, retired++ and go to FETCH with no side effects. If op is HALT, go to HALT. Otherwise go to EXEC.
  - EXEC, branch: pc <= imm, retired++, go to FETCH.
  - EXEC, LDR/STR: go to MEM.
  - EXEC, ALU op: go to WB.
  - MEM: mem_req=1, sel_add_bus=1, ram_rw=(op==STR). Waits for mem_ready. On completion, LDR goes to WB; STR does retired++ and goes to FETCH.
  - WB: reg_we=1, sel_ldr_bus=(op==LDR), flags_we=(s & ALU op). Then retired++ and go to FETCH.
  - HALT: absorbing state; only reset leaves it.
- Output rules:
  - All strobes and selects decode only from the state register and ir. There is no combinational path from any input to any output.
  - Outside the states listed above, every strobe and select is 0.
- start and mem_ready are ignored in any state where they are not consumed.
- retired wraps from 16'hFFFF to 0.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, ir=0, retired=0, halted=0, and every strobe and select 0.
- Reset assertion mid-transfer aborts immediately. No write strobe may be asserted while rst=0.
- Minimum latency with mem_ready held at 1:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB)
  - LDR: 5 cycles
  - STR: 4 cycles
  - B: 3 cycles
  - condition-failed instruction: 2 cycles
- Each mem_ready wait cycle adds one cycle. mem_req stays high and the address stays stable until the transfer completes.
- reg_we and flags_we are exactly one cycle wide per instruction.
- Back-to-back instructions have no idle cycles: the cycle after WB is FETCH.
- The flags written in WB are visible to the next instruction's DECODE.

## Test plan
- Reset with no start for 5 cycles -> state=0, pc=0, all strobes 0. Then start=1 for one cycle -> mem_req=1 and sel_add_bus=0 on the next cycle.
- ALU op 32'h0_1_8_xxxxx (AL, op=1, s=1), mem_ready always 1 -> reg_we and flags_we each high for exactly 1 cycle, 4 cycles after FETCH entry; pc=1; retired=1.
- LDR (op=C) with mem_ready low for 3 cycles in MEM -> mem_req=1 and sel_add_bus=1 held for 4 cycles, then WB with sel_ldr_bus=1 and reg_we=1; total 8 cycles.
- Condition tests with flags=4'b0100 (Z=1): EQ ALU op -> writes occur. NE ALU op -> no reg_we or flags_we, retired still increments, FETCH follows DECODE.
- B with imm=16'hFFFF, then execute the instruction fetched at FFFF -> pc=16'h0000 after that fetch (wrap).
- Drop rst low during MEM of an STR -> ram_rw and mem_req go to 0 immediately and pc=RESET_PC. Separately, a HALT opcode -> halted=1 held for 20 cycles regardless of start.
